// File: rtl/simd_dmem_readback_pkg.sv
// Shared definitions for the PE DMEM readback engine: defaults, state encoding, lane width helper.
// Optional checksum accumulator is enabled by defining DEF_DMEM_READBACK_CHECKSUM_EN.
`ifndef DEF_PE_DATA_WIDTH
`define DEF_PE_DATA_WIDTH 32
`endif
`ifndef DEF_PE_NUM
`define DEF_PE_NUM 8
`endif
`ifndef DEF_PE_D_MEM_ADDR_WIDTH
`define DEF_PE_D_MEM_ADDR_WIDTH 10
`endif

package simd_dmem_readback_pkg;

  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_DATA_WIDTH  = `DEF_PE_DATA_WIDTH;
  localparam int DEF_NUM         = `DEF_PE_NUM;
  localparam int DEF_WADDR_WIDTH = `DEF_PE_D_MEM_ADDR_WIDTH;
  localparam int DEF_LANE_W      = lane_w(DEF_NUM);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD    = 3'd1;
  localparam logic [2:0] ST_CAP   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/simd_dmem_readback_row_serializer.sv
// Row buffer plus lane serializer: captures one DMEM row and hands it out lane by lane
// over a registered valid/ready stream.
module simd_dmem_row_serializer #(
  parameter int DATA_WIDTH  = 32,
  parameter int PE_NUM      = 8,
  parameter int WADDR_WIDTH = 10,
  parameter int LANE_W      = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic                         flush,
  input  logic [PE_NUM*DATA_WIDTH-1:0] row_data,
  input  logic [WADDR_WIDTH-1:0]       row_addr,
  input  logic                         ready,
  output logic                         valid,
  output logic [DATA_WIDTH-1:0]        data,
  output logic [LANE_W-1:0]            lane,
  output logic [WADDR_WIDTH-1:0]       addr,
  output logic                         last_lane_accepted
);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PE_NUM - 1);

  logic [DATA_WIDTH-1:0]  row_in    [PE_NUM];
  logic [DATA_WIDTH-1:0]  row_buf_q [PE_NUM];
  logic [DATA_WIDTH-1:0]  row_buf_d [PE_NUM];
  logic [LANE_W-1:0]      lane_q, lane_d, lane_next;
  logic                   valid_q, valid_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [WADDR_WIDTH-1:0] addr_q, addr_d;
  logic                   xfer;

  genvar gi;
  generate
    for (gi = 0; gi < PE_NUM; gi++) begin : g_unpack
      assign row_in[gi] = row_data[DATA_WIDTH*gi +: DATA_WIDTH];
    end
  endgenerate

  assign xfer               = valid_q && ready;
  assign last_lane_accepted = xfer && (lane_q == LAST_LANE);
  assign lane_next          = lane_q + 1'b1;

  // Output word is preloaded from the buffer so data never passes through a mux after the flops.
  always_comb begin
    row_buf_d = row_buf_q;
    lane_d    = lane_q;
    valid_d   = valid_q;
    data_d    = data_q;
    addr_d    = addr_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      row_buf_d = row_in;
      lane_d    = '0;
      valid_d   = 1'b1;
      data_d    = row_in[0];
      addr_d    = row_addr;
    end else if (xfer) begin
      if (lane_q == LAST_LANE) begin
        valid_d = 1'b0;
      end else begin
        lane_d = lane_next;
        data_d = row_buf_q[lane_next];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PE_NUM; i++) row_buf_q[i] <= '0;
      lane_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      row_buf_q <= row_buf_d;
      lane_q    <= lane_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign lane  = lane_q;
  assign addr  = addr_q;

endmodule

// File: rtl/simd_dmem_readback.sv
// PE DMEM readback engine: reads rows over the bus port and streams them out lane by lane.
// Define DEF_DMEM_READBACK_CHECKSUM_EN to enable the running checksum on oChecksum.
import simd_dmem_readback_pkg::*;

module simd_dmem_readback #(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int PE_NUM      = DEF_NUM,
  parameter int WADDR_WIDTH = DEF_WADDR_WIDTH
) (
  input  logic                               iClk,
  input  logic                               iReset,
  input  logic                               iStart,
  input  logic                               iAbort,
  input  logic [WADDR_WIDTH-1:0]             iBase_Addr,
  input  logic [WADDR_WIDTH:0]               iWord_Count,
  output logic                               oBusy,
  output logic                               oDone,
  output logic [PE_NUM-1:0]                  oBus_DMEM_Valid,
  output logic [PE_NUM*(WADDR_WIDTH+2)-1:0]  oBus_DMEM_Address,
  output logic [PE_NUM-1:0]                  oBus_DMEM_Write_Enable,
  input  logic [PE_NUM*DATA_WIDTH-1:0]       iBus_DMEM_Read_Data,
  output logic                               oStream_Valid,
  output logic [DATA_WIDTH-1:0]              oStream_Data,
  output logic [lane_w(PE_NUM)-1:0]          oStream_PE,
  output logic [WADDR_WIDTH-1:0]             oStream_Addr,
  input  logic                               iStream_Ready,
  output logic [DATA_WIDTH-1:0]              oChecksum
);
  localparam int LANE_W = lane_w(PE_NUM);

  logic [2:0]             state_q, state_d;
  logic [WADDR_WIDTH-1:0] base_q, base_d;
  logic [WADDR_WIDTH:0]   count_q, count_d;
  logic [WADDR_WIDTH:0]   row_q, row_d, row_inc;
  logic [WADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                   busy_q, busy_d, done_q, done_d, bus_valid_q, bus_valid_d;
  logic                   last_lane_accepted, load, flush;

  assign row_inc = row_q + 1'b1;
  assign load    = (state_q == ST_CAP) && !iAbort;
  assign flush   = (state_q != ST_IDLE) && iAbort;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      count_q   <= '0;
      row_q     <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      count_q   <= count_d;
      row_q     <= row_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    row_d     = row_q;
    rd_addr_d = rd_addr_q;
    case (state_q)
      ST_IDLE: if (iStart) begin
        base_d    = iBase_Addr;
        count_d   = iWord_Count;
        row_d     = '0;
        rd_addr_d = iBase_Addr;
        state_d   = (iWord_Count == '0) ? ST_DONE : ST_RD;
      end
      ST_RD:    state_d = ST_CAP;
      ST_CAP:   state_d = ST_DRAIN;
      ST_DRAIN: if (last_lane_accepted) begin
        row_d = row_inc;
        if (row_inc == count_q) begin
          state_d = ST_DONE;
        end else begin
          state_d   = ST_RD;
          rd_addr_d = base_q + row_inc[WADDR_WIDTH-1:0];
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // Status outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    bus_valid_d = (state_d == ST_RD);
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bus_valid_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      bus_valid_q <= bus_valid_d;
    end
  end

  assign oBusy                  = busy_q;
  assign oDone                  = done_q;
  assign oBus_DMEM_Valid        = {PE_NUM{bus_valid_q}};
  assign oBus_DMEM_Write_Enable = '0;

  genvar gi;
  generate
    for (gi = 0; gi < PE_NUM; gi++) begin : g_addr
      assign oBus_DMEM_Address[(WADDR_WIDTH+2)*gi +: (WADDR_WIDTH+2)] = {rd_addr_q, 2'b00};
    end
  endgenerate

  simd_dmem_row_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .PE_NUM     (PE_NUM),
    .WADDR_WIDTH(WADDR_WIDTH),
    .LANE_W     (LANE_W)
  ) u_serializer (
    .clk               (iClk),
    .rst               (iReset),
    .load              (load),
    .flush             (flush),
    .row_data          (iBus_DMEM_Read_Data),
    .row_addr          (rd_addr_q),
    .ready             (iStream_Ready),
    .valid             (oStream_Valid),
    .data              (oStream_Data),
    .lane              (oStream_PE),
    .addr              (oStream_Addr),
    .last_lane_accepted(last_lane_accepted)
  );

`ifdef DEF_DMEM_READBACK_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if ((state_q == ST_IDLE) && iStart) csum_d = '0;
    else if (oStream_Valid && iStream_Ready) csum_d = csum_q + oStream_Data;
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign oChecksum = csum_q;
`else
  assign oChecksum = '0;
`endif

endmodule
